// File: rtl/cast_pkg.sv
// cast_pkg: op encoding, width helpers and the generic narrowing function for cast_select_pipe
package cast_pkg;
    typedef enum logic [1:0] {
        OP_SEL = 2'd0,
        OP_ADD = 2'd1,
        OP_ACC = 2'd2,
        OP_CLR = 2'd3
    } op_e;

    localparam int MAX_W = 128;

    function automatic int max_w(input int x, input int y);
        return x > y ? x : y;
    endfunction

    function automatic int int_w(input int a_w, input int b_w);
        return max_w(a_w, b_w) + 1;
    endfunction

    // x arrives already extended to MAX_W; returns {ovf, value} with the result in the low res_w bits
    function automatic logic [MAX_W:0] narrow(input logic [MAX_W-1:0] x, input int res_w,
                                              input bit sgn, input bit sat);
        logic [MAX_W-1:0] one, top, hi_b, lo_b, bnd;
        logic ovf;
        one = MAX_W'(1);
        if (sgn) begin
            top = $signed(x) >>> (res_w - 1);
            hi_b = (one << (res_w - 1)) - one;
            lo_b = ~hi_b;
            ovf = top != '0 && top != '1;
        end else begin
            top = x >> res_w;
            hi_b = (one << res_w) - one;
            lo_b = '0;
            ovf = top != '0;
        end
        bnd = sgn && x[MAX_W-1] ? lo_b : hi_b;
        return {ovf, ovf && sat ? bnd : x};
    endfunction
endpackage

// File: rtl/cast_narrow.sv
// cast_narrow: narrow an X_W-bit value to RES_W bits, wrapping or saturating, and flag overflow
module cast_narrow
    import cast_pkg::*;
#(
    parameter int X_W    = 33,
    parameter int RES_W  = 32,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic [X_W-1:0]   x,
    output logic [RES_W-1:0] res,
    output logic             ovf
);
    logic [MAX_W-1:0]       x_ext;
    logic [MAX_W-RES_W-1:0] unused_hi;

    always_comb begin
        x_ext = {{(MAX_W-X_W){SIGNED != 0 && x[X_W-1]}}, x};
        {ovf, unused_hi, res} = narrow(x_ext, RES_W, SIGNED != 0, SAT != 0);
    end
endmodule

// File: rtl/cast_select_pipe.sv
// cast_select_pipe: two-stage extend/select/add/accumulate pipe with narrowing and valid/ready flow control
module cast_select_pipe
    import cast_pkg::*;
#(
    parameter int A_W    = 16,
    parameter int B_W    = 32,
    parameter int RES_W  = 32,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_cond,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_res,
    output logic             out_ovf,
    output logic             ovf_sticky
);
    localparam int INT_W = int_w(A_W, B_W);
    // wide enough that acc + v never wraps before narrowing
    localparam int ACC_W = max_w(INT_W, RES_W) + 1;
    localparam bit SGN = SIGNED != 0;

    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    op_e              s1_op_q, s1_op_d;
    logic [INT_W-1:0] s1_v_q, s1_v_d, ext_a, ext_b;
    logic [RES_W-1:0] res_q, res_d, acc_q, acc_d, dir_res, acc_res;
    logic             ovf_q, ovf_d, sticky_q, sticky_d, dir_ovf, acc_ovf;
    logic             s1_en, s2_en, s1_load, s2_load;
    logic [ACC_W-1:0] acc_sum;

    always_comb begin
        ext_a = {{(INT_W-A_W){SGN && in_a[A_W-1]}}, in_a};
        ext_b = {{(INT_W-B_W){SGN && in_b[B_W-1]}}, in_b};
        s2_en = !s2_valid_q || out_ready;
        s1_en = !s1_valid_q || s2_en;
        s1_load = s1_en && in_valid;
        s2_load = s2_en && s1_valid_q;
        s1_valid_d = s1_en ? in_valid : s1_valid_q;
        s1_op_d = s1_load ? op_e'(in_op) : s1_op_q;
        s1_v_d = !s1_load ? s1_v_q :
                 op_e'(in_op) == OP_ADD ? ext_a + ext_b :
                 op_e'(in_op) == OP_CLR ? '0 :
                 in_cond ? ext_a : ext_b;
        acc_sum = {{(ACC_W-RES_W){SGN && acc_q[RES_W-1]}}, acc_q}
                + {{(ACC_W-INT_W){SGN && s1_v_q[INT_W-1]}}, s1_v_q};
        s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
        res_d = !s2_load ? res_q : s1_op_q == OP_ACC ? acc_res : dir_res;
        ovf_d = !s2_load ? ovf_q : s1_op_q == OP_ACC ? acc_ovf : dir_ovf;
        acc_d = s2_load && s1_op_q == OP_ACC ? acc_res :
                s2_load && s1_op_q == OP_CLR ? '0 : acc_q;
        sticky_d = sticky_q || (s2_load && ovf_d);
    end

    cast_narrow #(.X_W(INT_W), .RES_W(RES_W), .SIGNED(SIGNED), .SAT(SAT)) u_dir (
        .x(s1_v_q), .res(dir_res), .ovf(dir_ovf)
    );

    cast_narrow #(.X_W(ACC_W), .RES_W(RES_W), .SIGNED(SIGNED), .SAT(SAT)) u_acc (
        .x(acc_sum), .res(acc_res), .ovf(acc_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            acc_q      <= '0;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
            acc_q      <= acc_d;
            sticky_q   <= sticky_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_op_q <= s1_op_d;
        s1_v_q  <= s1_v_d;
    end

    assign in_ready   = s1_en;
    assign out_valid  = s2_valid_q;
    assign out_res    = res_q;
    assign out_ovf    = ovf_q;
    assign ovf_sticky = sticky_q;
endmodule
